// File: rtl/pipo_arb_pkg.sv
// Shared types and constants for the PIPO load arbiter and its round-robin picker.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents:
//   arb_state_t   - arbiter FSM state encoding (IDLE, LOAD, HOLD)
//   DEF_*         - default parameter values for pipo_load_arbiter
//   clog2_min1()  - ceil(log2(value)) clamped to at least one bit
package pipo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } arb_state_t;

   localparam int DEF_N_REQ       = 4;
   localparam int DEF_WIDTH       = 4;
   localparam int DEF_HOLD_CYCLES = 2;

   // Index and counter widths must never collapse to zero bits, even when
   // only one value is representable (e.g. HOLD_CYCLES = 1 needs counter value 0).
   function automatic int clog2_min1(input int value);
      int bits;
      bits = 0;
      while ((1 << bits) < value) begin
         bits = bits + 1;
      end
      if (bits < 1) begin
         bits = 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/pipo_load_arbiter_pick.sv
// Round-robin priority picker: first asserted request at or after ptr, with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
//
// Ports:
//   req   in  N_REQ  request levels
//   ptr   in  IDX_W  highest-priority index for this search
//   found out 1      at least one request is asserted
//   idx   out IDX_W  winning index (0 when found is low)
module rr_priority_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand;

   // Walk candidates from the farthest (ptr+N_REQ-1) back to ptr itself, so the
   // nearest asserted request at or after ptr is the last assignment and wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(ptr) + k) % N_REQ);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter in front of a PIPO register: arbitrate, one-cycle load, hold ownership.
// Latency: grant/load_en one cycle after the request is sampled in IDLE; done HOLD_CYCLES later.
// Backpressure: none; a granted transaction always runs to completion, requests wait in IDLE.
//
// Ports:
//   clk        in  1            rising-edge clock
//   rst_n      in  1            asynchronous active-low reset
//   req        in  N_REQ        per-requester request level
//   req_data   in  N_REQ*WIDTH  requester i's word at [i*WIDTH +: WIDTH]
//   gnt        out N_REQ        registered one-hot grant (LOAD and HOLD)
//   load_en    out 1            PIPO load strobe, one cycle per grant
//   load_data  out WIDTH        winner word latched at arbitration, drives PIPO input
//   done       out N_REQ        pulse to the owner on its last HOLD cycle
//   busy       out 1            high during LOAD and HOLD
//   owner      out IDX_W        index of the current or most recent winner
module pipo_load_arbiter
   import pipo_arb_pkg::*;
#(
   parameter int N_REQ       = DEF_N_REQ,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   localparam int IDX_W      = clog2_min1(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       gnt,
   output logic                   load_en,
   output logic [WIDTH-1:0]       load_data,
   output logic [N_REQ-1:0]       done,
   output logic                   busy,
   output logic [IDX_W-1:0]       owner
);

   localparam int              CNT_W     = clog2_min1(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_nxt;
   logic [IDX_W-1:0] owner_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic [N_REQ-1:0] gnt_nxt;
   logic [N_REQ-1:0] done_nxt;
   logic             load_en_nxt;
   logic             busy_nxt;

   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic [WIDTH-1:0] pick_word;

   rr_priority_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] sel);
      logic [N_REQ-1:0] vec;
      vec      = '0;
      vec[sel] = 1'b1;
      return vec;
   endfunction

   // Word of the current arbitration winner; only consumed in IDLE.
   always_comb begin
      pick_word = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) begin
            pick_word = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state logic. Every output is registered, so the *_nxt values describe
   // what the outputs must show during the cycle after the coming edge.
   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      owner_nxt   = owner;
      cnt_nxt     = cnt;
      data_nxt    = load_data;
      gnt_nxt     = '0;
      done_nxt    = '0;
      load_en_nxt = 1'b0;
      busy_nxt    = 1'b0;

      unique case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt   = LOAD;
               owner_nxt   = pick_idx;
               ptr_nxt     = (pick_idx == IDX_LAST) ? '0 : pick_idx + IDX_W'(1);
               data_nxt    = pick_word;
               gnt_nxt     = onehot(pick_idx);
               load_en_nxt = 1'b1;
               busy_nxt    = 1'b1;
            end
         end

         LOAD: begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_LAST;
            gnt_nxt   = onehot(owner);
            busy_nxt  = 1'b1;
            // A single-cycle hold makes the first HOLD cycle also the last one.
            if (HOLD_LAST == '0) begin
               done_nxt = onehot(owner);
            end
         end

         HOLD: begin
            if (cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt  = cnt - CNT_W'(1);
               gnt_nxt  = onehot(owner);
               busy_nxt = 1'b1;
               // Counter reaching 0 next cycle marks that cycle as the last hold cycle.
               if (cnt == CNT_W'(1)) begin
                  done_nxt = onehot(owner);
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         owner     <= '0;
         load_data <= '0;
         gnt       <= '0;
         done      <= '0;
         load_en   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         cnt       <= cnt_nxt;
         owner     <= owner_nxt;
         load_data <= data_nxt;
         gnt       <= gnt_nxt;
         done      <= done_nxt;
         load_en   <= load_en_nxt;
         busy      <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Scoreboard bench for pipo_load_arbiter: a HOLD_CYCLES=2 and a HOLD_CYCLES=1 build share stimulus.
// The driver predicts each grant from round-robin rules and pushes it; a monitor pops on load_en.
// The monitor also checks gnt/busy/done/owner/load_data every cycle and a bench-side PIPO register.
module tb_pipo_load_arbiter;

   localparam int NR    = 4;
   localparam int W     = 4;
   localparam int QSIZE = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req;
   logic [NR*W-1:0] req_data;

   logic [NR-1:0] gnt       [2];
   logic          load_en   [2];
   logic [W-1:0]  load_data [2];
   logic [NR-1:0] done      [2];
   logic          busy      [2];
   logic [1:0]    owner     [2];
   logic [W-1:0]  pipo      [2];

   always #5 clk = ~clk;

   pipo_load_arbiter #(.N_REQ(NR), .WIDTH(W), .HOLD_CYCLES(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
      .gnt(gnt[0]), .load_en(load_en[0]), .load_data(load_data[0]),
      .done(done[0]), .busy(busy[0]), .owner(owner[0])
   );

   pipo_load_arbiter #(.N_REQ(NR), .WIDTH(W), .HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
      .gnt(gnt[1]), .load_en(load_en[1]), .load_data(load_data[1]),
      .done(done[1]), .busy(busy[1]), .owner(owner[1])
   );

   // Stand-in for the PIPO register each arbiter feeds.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (load_en[d]) pipo[d] <= load_data[d];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- reference model state (driver side) ----------------
   int          fifo_w [2][QSIZE];
   int          fifo_c [2][QSIZE];
   logic [W-1:0] fifo_d [2][QSIZE];
   int          wr       [2];
   int          mptr     [2];
   int          next_arb [2];

   // ---------------- monitor state ----------------
   int          rd       [2];
   logic        cur_valid[2];
   int          cur_w    [2];
   int          cur_load [2];
   logic [W-1:0] cur_d   [2];
   int          last_w   [2];
   logic [W-1:0] last_d  [2];
   logic        drain_check = 1'b0;
   logic        final_done  = 1'b0;

   int checks = 0;
   int errors = 0;

   function automatic int hold_of(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   function automatic int rr_pick(input int start, input logic [NR-1:0] r);
      for (int k = 0; k < NR; k++) begin
         if (r[(start + k) % NR] == 1'b1) return (start + k) % NR;
      end
      return -1;
   endfunction

   task automatic chk(input string nm, input int d, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, d, cyc, act, exp);
      end
   endtask

   // Called right after inputs change: req seen now is sampled at the next edge.
   // A free arbiter grants it; LOAD follows one cycle later and the arbiter
   // can arbitrate again HOLD+2 cycles after this one.
   task automatic model_cycle();
      int w;
      for (int d = 0; d < 2; d++) begin
         if (rst_n && cyc >= next_arb[d] && req != '0) begin
            w = rr_pick(mptr[d], req);
            fifo_w[d][wr[d] % QSIZE] = w;
            fifo_d[d][wr[d] % QSIZE] = req_data[w*W +: W];
            fifo_c[d][wr[d] % QSIZE] = cyc + 1;
            wr[d]++;
            next_arb[d] = cyc + hold_of(d) + 2;
            mptr[d] = (w + 1) % NR;
         end
      end
   endtask

   task automatic step(input logic [NR-1:0] r, input logic [NR*W-1:0] dat);
      @(posedge clk);
      #1;
      req      = r;
      req_data = dat;
      model_cycle();
   endtask

   task automatic release_reset(input logic [NR-1:0] r, input logic [NR*W-1:0] dat);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      req      = r;
      req_data = dat;
      for (int d = 0; d < 2; d++) next_arb[d] = cyc;
      model_cycle();
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk or negedge rst_n) begin
      logic [NR-1:0] eg;
      logic [NR-1:0] ed;
      int h;
      int slot;
      if (!rst_n) begin
         #1;
         for (int d = 0; d < 2; d++) begin
            chk("rst_gnt",       d, int'(gnt[d]),       0);
            chk("rst_load_en",   d, int'(load_en[d]),   0);
            chk("rst_busy",      d, int'(busy[d]),      0);
            chk("rst_done",      d, int'(done[d]),      0);
            chk("rst_owner",     d, int'(owner[d]),     0);
            chk("rst_load_data", d, int'(load_data[d]), 0);
            rd[d]        = wr[d];
            cur_valid[d] = 1'b0;
            last_w[d]    = 0;
            last_d[d]    = '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            h = hold_of(d);
            if (load_en[d]) begin
               if (rd[d] == wr[d]) begin
                  chk("load_en_unexpected", d, int'(load_en[d]), 0);
               end else begin
                  slot = rd[d] % QSIZE;
                  chk("load_cycle", d, cyc, fifo_c[d][slot]);
                  cur_valid[d] = 1'b1;
                  cur_w[d]     = fifo_w[d][slot];
                  cur_d[d]     = fifo_d[d][slot];
                  cur_load[d]  = cyc;
                  last_w[d]    = fifo_w[d][slot];
                  last_d[d]    = fifo_d[d][slot];
                  rd[d]++;
               end
            end else if (rd[d] != wr[d] && fifo_c[d][rd[d] % QSIZE] <= cyc) begin
               chk("load_en_missing", d, int'(load_en[d]), 1);
               rd[d]++;
            end
            eg = '0;
            ed = '0;
            if (cur_valid[d] && cyc <= cur_load[d] + h) eg = NR'(1 << cur_w[d]);
            if (cur_valid[d] && cyc == cur_load[d] + h) ed = NR'(1 << cur_w[d]);
            chk("gnt",       d, int'(gnt[d]),       int'(eg));
            chk("busy",      d, int'(busy[d]),      int'(eg != '0));
            chk("done",      d, int'(done[d]),      int'(ed));
            chk("owner",     d, int'(owner[d]),     last_w[d]);
            chk("load_data", d, int'(load_data[d]), int'(last_d[d]));
            if (cur_valid[d] && cyc == cur_load[d] + 1) begin
               chk("pipo", d, int'(pipo[d]), int'(cur_d[d]));
            end
            if (drain_check && !final_done) begin
               chk("drained", d, rd[d], wr[d]);
            end
         end
         if (drain_check) final_done = 1'b1;
      end
   end

   // ---------------- driver ----------------
   initial begin
      logic [NR-1:0] r;
      rst_n    = 1'b0;
      req      = '0;
      req_data = '0;
      for (int d = 0; d < 2; d++) begin
         wr[d] = 0; mptr[d] = 0; next_arb[d] = 0;
      end
      repeat (3) @(posedge clk);
      release_reset('0, '0);

      // Single request from index 2 with word A.
      step(4'b0100, 16'h0A00);
      step(4'b0000, 16'h0A00);
      repeat (6) step(4'b0000, 16'h0000);

      // All requesters held: rotating grants.
      repeat (22) step(4'b1111, 16'h4321);
      repeat (6) step(4'b0000, 16'h0000);

      // Requester 1, word 5; drop req in LOAD, change word to F in HOLD.
      step(4'b0010, 16'h0050);
      step(4'b0000, 16'h0050);
      step(4'b0000, 16'h00F0);
      repeat (5) step(4'b0000, 16'h00F0);

      // Reset in the middle of HOLD, then 1001 must go to index 0.
      step(4'b0100, 16'h0B00);
      step(4'b0000, 16'h0B00);
      step(4'b0000, 16'h0B00);
      #2;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) mptr[d] = 0;
      repeat (2) step(4'b0000, 16'h0000);
      release_reset(4'b1001, 16'h7003);
      step(4'b0000, 16'h0000);
      repeat (6) step(4'b0000, 16'h0000);

      // Idle stretch.
      repeat (20) step(4'b0000, 16'h0000);

      // Back-to-back pair requests.
      repeat (18) step(4'b0011, 16'h00C6);
      repeat (6) step(4'b0000, 16'h0000);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom);
         step(r, (NR*W)'($urandom));
      end

      repeat (12) step(4'b0000, 16'h0000);
      drain_check = 1'b1;
      repeat (3) @(posedge clk);
      if (!final_done) begin
         checks++;
         errors++;
         $display("FAIL drain_check: monitor did not complete final check");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
